// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-way round-robin arbiter with bounded grant tenure
//
// Purpose:
//   Sequences access to a single 16-slot shared resource. Selects one
//   requester at a time in rotating priority order. A grant lasts at most
//   HOLD_MAX cycles, and every grant is followed by one idle cycle.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles per tenure (1..255)
//   CW        tenure counter width, 2**CW > HOLD_MAX
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   En         enable; low blocks new grants and revokes the current one
//   req[0:15]  request vector, req[k] for requester k
//   gnt[0:15]  registered one-hot grant, gnt[k] for requester k
//   gnt_id     index of the current or most recent winner
//   gnt_valid  a grant is active (OR of gnt)
//   busy       FSM is in GRANT (same as gnt_valid)

module rr_arbiter_16 #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic [0:15] req,
  output logic [0:15] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [3:0]    ptr;
  logic [CW-1:0] cnt;

  logic [3:0]    win;
  logic          win_ok;
  logic [3:0]    scan_idx;

  // Index k sets bit k of a [0:15] vector, so gnt[k] belongs to requester k.
  function automatic logic [0:15] decode_4to16(input logic [3:0] k);
    logic [0:15] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Rotating priority scan: start at ptr, wrap modulo 16 through the 4-bit
  // adder, and keep the first requester found.
  always_comb begin
    win      = '0;
    win_ok   = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr + 4'(i);
      if (!win_ok && req[scan_idx]) begin
        win    = scan_idx;
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (En && win_ok) begin
            gnt_id    <= win;
            gnt       <= decode_4to16(win);
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            cnt       <= CW'(1);
            // Priority moves past the winner now, so a preempted requester
            // yields to everyone else that is waiting.
            ptr       <= win + 4'd1;
            state     <= GRANT;
          end
        end

        GRANT: begin
          // Disable, release and timeout all end the tenure the same way;
          // gnt_id is left holding the last winner.
          if (!En || !req[gnt_id] || (cnt == CW'(HOLD_MAX))) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - randomized and directed checks of rr_arbiter_16 against a reference model
module tb_rr_arbiter_16;

  localparam int HOLD_MAX = 8;
  localparam int CW       = 8;

  logic        clk;
  logic        rst;
  logic        En;
  logic [0:15] req;
  logic [0:15] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        busy;

  int checks;
  int errors;

  // Reference model: owner is the granted requester, or -1 when idle.
  int m_owner;
  int m_last;
  int m_tenure;
  int m_next_first;

  rr_arbiter_16 #(.HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .En        (En),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next model state from the inputs present at the coming clock edge.
  task automatic model_next();
    if (rst) begin
      m_owner      = -1;
      m_last       = 0;
      m_tenure     = 0;
      m_next_first = 0;
    end else if (m_owner < 0) begin
      if (En) begin
        for (int k = 0; k < 16; k++) begin
          int cand;
          cand = (m_next_first + k) % 16;
          if (req[cand]) begin
            m_owner      = cand;
            m_last       = cand;
            m_tenure     = 1;
            m_next_first = (cand + 1) % 16;
            break;
          end
        end
      end
    end else begin
      if (!En || !req[m_owner] || m_tenure >= HOLD_MAX)
        m_owner = -1;
      else
        m_tenure++;
    end
  endtask

  task automatic compare_outputs();
    logic [0:15] exp_gnt;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_id", 32'(gnt_id), 32'(m_last));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int          order[$];
  logic [3:0]  trace_id[$];
  logic        trace_v[$];
  int          seg_id[$];
  int          seg_len[$];
  int          gap_len[$];

  initial begin
    checks  = 0;
    errors  = 0;
    m_owner = -1;
    m_last  = 0;
    m_tenure = 0;
    m_next_first = 0;
    rst = 1'b1;
    En  = 1'b1;
    req = '0;

    // Reset then idle
    do_reset(2);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_id", 32'(gnt_id), 32'h0);
    check("reset_valid", 32'(gnt_valid), 32'h0);
    repeat (5) step();

    // Single requester 5, held 3 cycles then dropped
    req[5] = 1'b1;
    step();
    check("single_first_id", 32'(gnt_id), 32'd5);
    check("single_first_gnt", 32'(gnt), 32'(16'h0400));
    step();
    step();
    req[5] = 1'b0;
    step();
    step();
    check("single_gap_valid", 32'(gnt_valid), 32'h0);
    check("single_gap_id", 32'(gnt_id), 32'd5);

    // Round-robin rotation with every requester active
    do_reset(1);
    req = '1;
    for (int c = 0; c < 60 && order.size() < 16; c++) begin
      step();
      if (m_owner >= 0 && m_tenure == 1) begin
        order.push_back(int'(gnt_id));
        req[m_owner] = 1'b0;
      end
    end
    check("rr_count", 32'(order.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check("rr_order", 32'((i < order.size()) ? order[i] : -1), 32'(i));
    req = '0;
    step();

    // Forced preemption between requesters 3 and 9
    do_reset(1);
    req[3] = 1'b1;
    req[9] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      trace_id.push_back(gnt_id);
      trace_v.push_back(gnt_valid);
    end
    begin
      int run;
      int gap;
      run = 0;
      gap = 0;
      for (int c = 0; c < trace_v.size(); c++) begin
        if (trace_v[c]) begin
          if (run == 0 && seg_id.size() > 0) gap_len.push_back(gap);
          if (run == 0) seg_id.push_back(int'(trace_id[c]));
          run++;
          gap = 0;
        end else begin
          if (run > 0) seg_len.push_back(run);
          run = 0;
          gap++;
        end
      end
    end
    check("pre_segments", 32'(seg_len.size() >= 3), 32'd1);
    check("pre_id0", 32'(seg_id.size() > 0 ? seg_id[0] : -1), 32'd3);
    check("pre_id1", 32'(seg_id.size() > 1 ? seg_id[1] : -1), 32'd9);
    check("pre_id2", 32'(seg_id.size() > 2 ? seg_id[2] : -1), 32'd3);
    check("pre_len0", 32'(seg_len.size() > 0 ? seg_len[0] : -1), 32'(HOLD_MAX));
    check("pre_len1", 32'(seg_len.size() > 1 ? seg_len[1] : -1), 32'(HOLD_MAX));
    check("pre_gap0", 32'(gap_len.size() > 0 ? gap_len[0] : -1), 32'd1);
    check("pre_gap1", 32'(gap_len.size() > 1 ? gap_len[1] : -1), 32'd1);
    req = '0;
    step();
    step();

    // Wrap-around: after granting 13, 15 beats 2, then 2 wins
    do_reset(1);
    req[13] = 1'b1;
    step();
    check("wrap_13", 32'(gnt_id), 32'd13);
    req[13] = 1'b0;
    step();
    req[2]  = 1'b1;
    req[15] = 1'b1;
    step();
    check("wrap_15", 32'(gnt_id), 32'd15);
    req[15] = 1'b0;
    step();
    step();
    check("wrap_2", 32'(gnt_id), 32'd2);
    check("wrap_2_gnt", 32'(gnt), 32'(16'h2000));
    req[2] = 1'b0;
    step();
    step();

    // En drop and reset in the middle of a tenure
    req[7] = 1'b1;
    step();
    step();
    En = 1'b0;
    step();
    check("en_low_valid", 32'(gnt_valid), 32'h0);
    step();
    check("en_low_hold", 32'(gnt), 32'h0);
    En = 1'b1;
    step();
    check("regrant_id", 32'(gnt_id), 32'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_id", 32'(gnt_id), 32'h0);
    req = '0;
    step();

    // Randomized traffic, requests mostly sticky so tenures run long
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      En  = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
